// File: rtl/mac_seq_control.sv
// Sequencer for a MAC neuron datapath: walks N_TERMS terms x N_NEURONS neurons per pass.
// Latency: acc_en/sel combinational on in_valid; en/done registered one cycle after last accepted term.
// Backpressure: in_valid=0 stalls all counters. Optional abort port under `define MAC_SEQ_ABORT_EN.
module mac_seq_control #(
    parameter int N_TERMS   = 4,
    parameter int N_NEURONS = 10,
    localparam int TERM_W   = (N_TERMS   > 1) ? $clog2(N_TERMS)   : 1,
    localparam int NEUR_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              sel,
    output logic              acc_en,
    output logic              en,
    output logic [TERM_W-1:0] term_idx,
    output logic [NEUR_W-1:0] neuron_idx,
    output logic              busy,
    output logic              done
`ifdef MAC_SEQ_ABORT_EN
    ,
    input  logic              abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(N_TERMS - 1);
    localparam logic [NEUR_W-1:0] NEUR_LAST = NEUR_W'(N_NEURONS - 1);

    state_t              state_q, state_d;
    logic [TERM_W-1:0]   term_idx_q, term_idx_d;
    logic [NEUR_W-1:0]   neuron_idx_q, neuron_idx_d;
    logic                en_q, en_d;
    logic                done_q, done_d;
    logic                accept;
    logic                abort_w;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            term_idx_q   <= '0;
            neuron_idx_q <= '0;
            en_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            term_idx_q   <= term_idx_d;
            neuron_idx_q <= neuron_idx_d;
            en_q         <= en_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        term_idx_d   = term_idx_q;
        neuron_idx_d = neuron_idx_q;
        en_d         = 1'b0;
        done_d       = 1'b0;
        accept       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RUN;
                    term_idx_d   = '0;
                    neuron_idx_d = '0;
                end
            end
            S_RUN: begin
                accept = in_valid;
                if (accept) begin
                    if (term_idx_q == TERM_LAST) begin
                        term_idx_d = '0;
                        en_d       = 1'b1;
                        if (neuron_idx_q == NEUR_LAST) begin
                            neuron_idx_d = '0;
                            state_d      = S_LAST;
                            done_d       = 1'b1;
                        end else begin
                            neuron_idx_d = neuron_idx_q + 1'b1;
                        end
                    end else begin
                        term_idx_d = term_idx_q + 1'b1;
                    end
                end
            end
            S_LAST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a result strobe earned this cycle.
        if (abort_w) begin
            state_d      = S_IDLE;
            term_idx_d   = '0;
            neuron_idx_d = '0;
            en_d         = 1'b0;
            done_d       = 1'b0;
            accept       = 1'b0;
        end
    end

    assign acc_en     = accept;
    assign sel        = accept && (term_idx_q == '0);
    assign en         = en_q;
    assign done       = done_q;
    assign busy       = (state_q == S_RUN);
    assign term_idx   = term_idx_q;
    assign neuron_idx = neuron_idx_q;

endmodule
